nasti_lite_burst_reader: RTL and testbench
==========================================

Name: nasti_lite_burst_reader

Overview:
Downstream stage for the narrower read path. It takes NASTI read bursts, for example from the narrower reader's slave port, and drives a single-beat NASTI-Lite read port. Each burst becomes len+1 sequential Lite reads with one read outstanding at a time. The returned beats are reassembled into a NASTI R burst carrying the original id and user.

Parameters:
ID_WIDTH, 2, NASTI ID size
ADDR_WIDTH, 32, address width on both sides
DATA_WIDTH, 32, data width on both sides (no width conversion)
USER_WIDTH, 1, size of USER field

Ports:
clk  in  1  clock
rstn  in  1  reset; synchronous, active-low
nasti_ar_id  in  ID_WIDTH  burst ID
nasti_ar_addr  in  ADDR_WIDTH  start address
nasti_ar_len  in  8  beats minus one
nasti_ar_size  in  3  log2 bytes per beat
nasti_ar_burst  in  2  burst type
nasti_ar_prot  in  3  protection; forwarded to every Lite AR
nasti_ar_user  in  USER_WIDTH  user; returned on every R beat
nasti_ar_valid  in  1  request valid
nasti_ar_ready  out  1  request accepted
nasti_r_id  out  ID_WIDTH  captured ar_id
nasti_r_data  out  DATA_WIDTH  beat data
nasti_r_resp  out  2  beat response
nasti_r_last  out  1  final beat
nasti_r_user  out  USER_WIDTH  captured ar_user
nasti_r_valid  out  1  beat valid
nasti_r_ready  in  1  beat accepted
lite_ar_addr  out  ADDR_WIDTH  single-beat address
lite_ar_prot  out  3  captured prot
lite_ar_valid  out  1  Lite request valid
lite_ar_ready  in  1  Lite request accepted
lite_r_data  in  DATA_WIDTH  Lite data
lite_r_resp  in  2  Lite response
lite_r_valid  in  1  Lite data valid
lite_r_ready  out  1  Lite data accepted
(lock/cache/qos/region are not carried; upstream ties them off.)

Behaviour:
- Reset (rstn low at a clk edge): state=S_IDLE, beat counter 0. nasti_r_valid, nasti_r_last, lite_ar_valid and lite_r_ready are all 0. nasti_ar_ready goes to 1 in S_IDLE.
- Reset mid-burst abandons the burst silently. The Lite slave must be reset together with this block.
- States:
  - S_IDLE: nasti_ar_ready=1. AR handshake captures id/addr/len/size/burst/prot/user and clears cnt. Next state is S_AR, or S_ERR if the burst is unsupported.
  - Unsupported means burst==WRAP (2'b10) or burst==reserved (2'b11), or 1<<size > DATA_WIDTH/8.
  - S_AR: lite_ar_valid=1, lite_ar_addr=cur_addr. On lite_ar handshake, go to S_R.
  - S_R: lite_r_ready = !nasti_r_valid || nasti_r_ready.
    - On lite_r handshake, register data/resp into the nasti_r output, set nasti_r_valid=1 and nasti_r_last=(cnt==len), then increment cnt.
    - If the beat was not last, advance cur_addr and go to S_AR. If it was last, go to S_DRAIN.
  - S_DRAIN: when the last beat is accepted, go to S_IDLE.
  - S_ERR: issues no Lite traffic. Generates len+1 beats with data=0 and resp=SLVERR (2'b10), last on beat len. Each beat is emitted when the R slot is free. After the last beat is accepted, go to S_IDLE.
- Address, INCR: the first beat uses the unaligned addr. Beat n≥1 uses (addr & ~((1<<size)-1)) + n·(1<<size), modulo 2^ADDR_WIDTH. There is no 4KB boundary check.
- Address, FIXED: every beat uses addr.
- nasti_r_valid holds until nasti_r_ready. Data/resp/last are stable while valid && !ready. The valid flag clears on acceptance unless a new beat loads in the same cycle.
- Lite resp is passed through per beat, with no stickiness. An error beat does not terminate the burst.
- Latency, for an always-ready Lite slave and always-ready R:
  - AR handshake at cycle 0 gives lite_ar_valid at cycle 1.
  - A Lite R handshake at cycle k gives nasti_r_valid at cycle k+1.
  - The next lite_ar_valid is asserted at cycle k+1.
- nasti_ar_ready is 0 in every state except S_IDLE. A new burst is accepted no earlier than the cycle after the last R beat is accepted.
- cnt is 8 bits. len=255 runs 256 beats with no wrap before last.

Test Plan:
- Single beat: INCR addr=0x100, len=0, size=2, id=1, user=1. Expect one Lite AR at 0x100. Lite data 0xDEADBEEF returns R data=0xDEADBEEF, resp=0, last=1, id=1, user=1.
- INCR burst: addr=0x1002, len=3, size=2. Expect Lite ARs at 0x1002, 0x1004, 0x1008, 0x100C in order. last is asserted only on the 4th beat. Never more than 1 Lite read is outstanding.
- Backpressure: hold nasti_r_ready=0 for 5 cycles on beat 2 of a len=3 burst. Expect R data to stay stable, lite_r_ready=0, no extra Lite AR issued, and no beat lost or duplicated.
- Errors: Lite resp=SLVERR on beat 1 of a len=2 burst. Expect R resp sequence 0, 2, 0 with all 3 beats delivered. A WRAP request with len=1 produces no Lite AR and 2 beats of resp=2'b10, data 0, last on beat 2.
- FIXED plus limits: FIXED addr=0x40, len=2 gives 3 Lite ARs all at 0x40. INCR addr=0xFFFFFFFC, len=1, size=2 gives Lite ARs at 0xFFFFFFFC then 0x00000000.
- Reset: drive rstn=0 for one cycle while in S_R. Expect nasti_r_valid=0 and lite_ar_valid=0 after the edge, and nasti_ar_ready=1 after reset releases. A following len=0 burst completes normally.

Source files
------------

// File: rtl/nasti_lite_burst_reader.sv
// Turns NASTI read bursts into one-at-a-time NASTI-Lite single-beat reads and
// reassembles the returned beats into an R burst carrying the original id/user.
module nasti_lite_burst_reader #(
    parameter int ID_WIDTH   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ID_WIDTH-1:0]   nasti_ar_id,
    input  logic [ADDR_WIDTH-1:0] nasti_ar_addr,
    input  logic [7:0]            nasti_ar_len,
    input  logic [2:0]            nasti_ar_size,
    input  logic [1:0]            nasti_ar_burst,
    input  logic [2:0]            nasti_ar_prot,
    input  logic [USER_WIDTH-1:0] nasti_ar_user,
    input  logic                  nasti_ar_valid,
    output logic                  nasti_ar_ready,
    output logic [ID_WIDTH-1:0]   nasti_r_id,
    output logic [DATA_WIDTH-1:0] nasti_r_data,
    output logic [1:0]            nasti_r_resp,
    output logic                  nasti_r_last,
    output logic [USER_WIDTH-1:0] nasti_r_user,
    output logic                  nasti_r_valid,
    input  logic                  nasti_r_ready,
    output logic [ADDR_WIDTH-1:0] lite_ar_addr,
    output logic [2:0]            lite_ar_prot,
    output logic                  lite_ar_valid,
    input  logic                  lite_ar_ready,
    input  logic [DATA_WIDTH-1:0] lite_r_data,
    input  logic [1:0]            lite_r_resp,
    input  logic                  lite_r_valid,
    output logic                  lite_r_ready
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_DRAIN, S_ERR} state_t;

    state_t                  state, state_nxt;
    logic [7:0]              cnt, len_q;
    logic [2:0]              size_q;
    logic [1:0]              burst_q;
    logic [ADDR_WIDTH-1:0]   cur_addr, step, next_addr;
    logic                    ar_hs, unsupported, slot_free, beat_last;
    logic                    beat_load;
    logic [DATA_WIDTH-1:0]   beat_data;
    logic [1:0]              beat_resp;

    assign ar_hs       = nasti_ar_valid && nasti_ar_ready;
    assign unsupported = nasti_ar_burst[1] || ((32'd1 << nasti_ar_size) > 32'(BYTES));
    assign slot_free   = !nasti_r_valid || nasti_r_ready;
    assign beat_last   = (cnt == len_q);

    // Align then step: beat 0 may be unaligned, every later beat is aligned.
    assign step      = ADDR_WIDTH'(1) << size_q;
    assign next_addr = (cur_addr & ~(step - ADDR_WIDTH'(1))) + step;

    assign lite_ar_addr = cur_addr;

    always_ff @(posedge clk) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        nasti_ar_ready = 1'b0;
        lite_ar_valid  = 1'b0;
        lite_r_ready   = 1'b0;
        beat_load      = 1'b0;
        beat_data      = lite_r_data;
        beat_resp      = lite_r_resp;
        case (state)
            S_IDLE: begin
                nasti_ar_ready = 1'b1;
                if (nasti_ar_valid) state_nxt = unsupported ? S_ERR : S_AR;
            end
            S_AR: begin
                lite_ar_valid = 1'b1;
                if (lite_ar_ready) state_nxt = S_R;
            end
            S_R: begin
                lite_r_ready = slot_free;
                if (lite_r_valid && slot_free) begin
                    beat_load = 1'b1;
                    state_nxt = beat_last ? S_DRAIN : S_AR;
                end
            end
            S_DRAIN: begin
                if (nasti_r_valid && nasti_r_ready) state_nxt = S_IDLE;
            end
            S_ERR: begin
                beat_data = '0;
                beat_resp = RESP_SLVERR;
                if (slot_free) begin
                    beat_load = 1'b1;
                    if (beat_last) state_nxt = S_DRAIN;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt           <= '0;
            len_q         <= '0;
            size_q        <= '0;
            burst_q       <= '0;
            cur_addr      <= '0;
            lite_ar_prot  <= '0;
            nasti_r_id    <= '0;
            nasti_r_user  <= '0;
            nasti_r_data  <= '0;
            nasti_r_resp  <= '0;
            nasti_r_last  <= 1'b0;
            nasti_r_valid <= 1'b0;
        end else begin
            if (ar_hs) begin
                cnt          <= '0;
                len_q        <= nasti_ar_len;
                size_q       <= nasti_ar_size;
                burst_q      <= nasti_ar_burst;
                cur_addr     <= nasti_ar_addr;
                lite_ar_prot <= nasti_ar_prot;
                nasti_r_id   <= nasti_ar_id;
                nasti_r_user <= nasti_ar_user;
            end
            if (nasti_r_ready) nasti_r_valid <= 1'b0;
            // A new beat loading in the same cycle overrides the clear above.
            if (beat_load) begin
                nasti_r_valid <= 1'b1;
                nasti_r_data  <= beat_data;
                nasti_r_resp  <= beat_resp;
                nasti_r_last  <= beat_last;
                cnt           <= cnt + 8'd1;
                if (state == S_R && !beat_last && burst_q == BURST_INCR)
                    cur_addr <= next_addr;
            end
        end
    end

endmodule

// File: tb/tb_nasti_lite_burst_reader.sv
// Directed bench: table of bursts with hand-computed Lite addresses and R beats,
// plus hand-written backpressure and mid-burst reset sequences.
module tb_nasti_lite_burst_reader;

    localparam logic [31:0] KEY  = 32'hDEADBFEF;  // slave data = addr ^ KEY
    localparam logic [31:0] NONE = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  nasti_ar_id;
    logic [31:0] nasti_ar_addr;
    logic [7:0]  nasti_ar_len;
    logic [2:0]  nasti_ar_size;
    logic [1:0]  nasti_ar_burst;
    logic [2:0]  nasti_ar_prot;
    logic [0:0]  nasti_ar_user;
    logic        nasti_ar_valid;
    logic        nasti_ar_ready;
    logic [1:0]  nasti_r_id;
    logic [31:0] nasti_r_data;
    logic [1:0]  nasti_r_resp;
    logic        nasti_r_last;
    logic [0:0]  nasti_r_user;
    logic        nasti_r_valid;
    logic        nasti_r_ready;
    logic [31:0] lite_ar_addr;
    logic [2:0]  lite_ar_prot;
    logic        lite_ar_valid;
    logic        lite_ar_ready;
    logic [31:0] lite_r_data;
    logic [1:0]  lite_r_resp;
    logic        lite_r_valid;
    logic        lite_r_ready;

    nasti_lite_burst_reader dut (
        .clk(clk), .rstn(rstn),
        .nasti_ar_id(nasti_ar_id), .nasti_ar_addr(nasti_ar_addr), .nasti_ar_len(nasti_ar_len),
        .nasti_ar_size(nasti_ar_size), .nasti_ar_burst(nasti_ar_burst), .nasti_ar_prot(nasti_ar_prot),
        .nasti_ar_user(nasti_ar_user), .nasti_ar_valid(nasti_ar_valid), .nasti_ar_ready(nasti_ar_ready),
        .nasti_r_id(nasti_r_id), .nasti_r_data(nasti_r_data), .nasti_r_resp(nasti_r_resp),
        .nasti_r_last(nasti_r_last), .nasti_r_user(nasti_r_user), .nasti_r_valid(nasti_r_valid),
        .nasti_r_ready(nasti_r_ready),
        .lite_ar_addr(lite_ar_addr), .lite_ar_prot(lite_ar_prot), .lite_ar_valid(lite_ar_valid),
        .lite_ar_ready(lite_ar_ready), .lite_r_data(lite_r_data), .lite_r_resp(lite_r_resp),
        .lite_r_valid(lite_r_valid), .lite_r_ready(lite_r_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        user;
        logic [2:0]  prot;
        logic [31:0] err_addr;
        int          n_lite;
        logic [31:0] a    [4];
        logic [1:0]  resp [4];
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [1:0]  id;
        logic        user;
    } beat_t;

    logic [31:0] la_q[$];
    beat_t       r_q[$];
    logic [31:0] err_addr = NONE;
    int          outstanding, max_out;
    int          n_vec = 0, n_err = 0;
    vec_t        vt[9];
    vec_t        bv;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Lite slave: always accepts AR, returns data one cycle later.
    initial begin
        logic        rst_seen, ar_hs, r_hs;
        logic [31:0] ar_a;
        lite_ar_ready = 1'b1;
        lite_r_valid  = 1'b0;
        lite_r_data   = '0;
        lite_r_resp   = '0;
        outstanding   = 0;
        max_out       = 0;
        forever begin
            @(negedge clk);
            rst_seen = !rstn;
            ar_hs    = lite_ar_valid && lite_ar_ready;
            r_hs     = lite_r_valid && lite_r_ready;
            ar_a     = lite_ar_addr;
            @(posedge clk); #1;
            if (rst_seen) begin
                lite_r_valid = 1'b0;
                outstanding  = 0;
            end else begin
                if (r_hs) begin
                    lite_r_valid = 1'b0;
                    outstanding--;
                end
                if (ar_hs) begin
                    la_q.push_back(ar_a);
                    outstanding++;
                    if (outstanding > max_out) max_out = outstanding;
                    lite_r_valid = 1'b1;
                    lite_r_data  = ar_a ^ KEY;
                    lite_r_resp  = (ar_a == err_addr) ? 2'b10 : 2'b00;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rstn && nasti_r_valid && nasti_r_ready)
                r_q.push_back('{nasti_r_data, nasti_r_resp, nasti_r_last, nasti_r_id, nasti_r_user});
        end
    end

    task automatic set_vec(input int i, input logic [1:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                           input logic user, input logic [2:0] prot, input logic [31:0] ea,
                           input int nl, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] a3,
                           input logic [1:0] r0, input logic [1:0] r1,
                           input logic [1:0] r2, input logic [1:0] r3);
        vt[i].id = id; vt[i].addr = addr; vt[i].len = len; vt[i].size = size;
        vt[i].burst = burst; vt[i].user = user; vt[i].prot = prot; vt[i].err_addr = ea;
        vt[i].n_lite = nl;
        vt[i].a[0] = a0; vt[i].a[1] = a1; vt[i].a[2] = a2; vt[i].a[3] = a3;
        vt[i].resp[0] = r0; vt[i].resp[1] = r1; vt[i].resp[2] = r2; vt[i].resp[3] = r3;
    endtask

    task automatic start_ar(input vec_t v);
        int waited = 0;
        @(posedge clk); #1;
        err_addr       = v.err_addr;
        nasti_ar_id    = v.id;
        nasti_ar_addr  = v.addr;
        nasti_ar_len   = v.len;
        nasti_ar_size  = v.size;
        nasti_ar_burst = v.burst;
        nasti_ar_prot  = v.prot;
        nasti_ar_user  = v.user;
        nasti_ar_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (nasti_ar_ready) break;
            waited++;
        end
        chk("ar_accept_wait", 32'(waited < 50), 32'd1);
        @(posedge clk); #1;
        nasti_ar_valid = 1'b0;
        chk("ar_ready_busy", 32'(nasti_ar_ready), 32'd0);
        chk("lite_ar_valid_lat", 32'(lite_ar_valid), 32'(v.n_lite > 0));
        if (v.n_lite > 0) chk("lite_ar_prot", 32'(lite_ar_prot), 32'(v.prot));
    endtask

    task automatic wait_done(input int br, input int n);
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            if (r_q.size() >= br + n) break;
        end
        chk("r_beat_count", 32'(r_q.size() - br), 32'(n));
        chk("ar_ready_after", 32'(nasti_ar_ready), 32'd1);
    endtask

    task automatic check_burst(input vec_t v, input int bla, input int br);
        beat_t b;
        logic [31:0] ed;
        chk("n_lite_ar", 32'(la_q.size() - bla), 32'(v.n_lite));
        for (int i = 0; i < v.n_lite; i++)
            if (bla + i < la_q.size()) chk($sformatf("lite_addr%0d", i), la_q[bla + i], v.a[i]);
        for (int i = 0; i <= int'(v.len); i++) begin
            if (br + i < r_q.size()) begin
                b  = r_q[br + i];
                ed = (v.n_lite > 0) ? (v.a[i] ^ KEY) : 32'd0;
                chk($sformatf("r_data%0d", i), b.data, ed);
                chk($sformatf("r_resp%0d", i), 32'(b.resp), 32'(v.resp[i]));
                chk($sformatf("r_last%0d", i), 32'(b.last), 32'(i == int'(v.len)));
                chk($sformatf("r_id%0d", i), 32'(b.id), 32'(v.id));
                chk($sformatf("r_user%0d", i), 32'(b.user), 32'(v.user));
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int bla, br;
        bla = la_q.size();
        br  = r_q.size();
        start_ar(v);
        wait_done(br, int'(v.len) + 1);
        check_burst(v, bla, br);
    endtask

    initial begin
        int bla, br;
        rstn = 1'b0; nasti_ar_valid = 1'b0; nasti_r_ready = 1'b1;
        nasti_ar_id = '0; nasti_ar_addr = '0; nasti_ar_len = '0; nasti_ar_size = '0;
        nasti_ar_burst = '0; nasti_ar_prot = '0; nasti_ar_user = '0;

        //      i id    addr           len  sz    burst  u     prot    err_addr       n  addresses                                          resp
        set_vec(0, 2'd1, 32'h0000_0100, 8'd0, 3'd2, 2'b01, 1'b1, 3'b000, NONE,          1, 32'h100, 0, 0, 0,                               0, 0, 0, 0);
        set_vec(1, 2'd2, 32'h0000_1002, 8'd3, 3'd2, 2'b01, 1'b0, 3'b010, NONE,          4, 32'h1002, 32'h1004, 32'h1008, 32'h100C,         0, 0, 0, 0);
        set_vec(2, 2'd3, 32'h0000_0200, 8'd2, 3'd2, 2'b01, 1'b1, 3'b001, 32'h0000_0204, 3, 32'h200, 32'h204, 32'h208, 0,                   0, 2, 0, 0);
        set_vec(3, 2'd0, 32'h0000_0300, 8'd1, 3'd2, 2'b10, 1'b1, 3'b000, NONE,          0, 0, 0, 0, 0,                                     2, 2, 0, 0);
        set_vec(4, 2'd1, 32'h0000_0040, 8'd2, 3'd2, 2'b00, 1'b0, 3'b100, NONE,          3, 32'h40, 32'h40, 32'h40, 0,                      0, 0, 0, 0);
        set_vec(5, 2'd2, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01, 1'b1, 3'b000, NONE,          2, 32'hFFFF_FFFC, 32'h0, 0, 0,                     0, 0, 0, 0);
        set_vec(6, 2'd3, 32'h0000_0080, 8'd0, 3'd3, 2'b01, 1'b0, 3'b000, NONE,          0, 0, 0, 0, 0,                                     2, 0, 0, 0);
        set_vec(7, 2'd1, 32'h0000_0011, 8'd2, 3'd1, 2'b01, 1'b1, 3'b111, NONE,          3, 32'h11, 32'h12, 32'h14, 0,                      0, 0, 0, 0);
        set_vec(8, 2'd2, 32'h0000_0090, 8'd0, 3'd2, 2'b11, 1'b0, 3'b000, NONE,          0, 0, 0, 0, 0,                                     2, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_r_valid", 32'(nasti_r_valid), 32'd0);
        chk("rst_r_last", 32'(nasti_r_last), 32'd0);
        chk("rst_lite_ar_valid", 32'(lite_ar_valid), 32'd0);
        chk("rst_lite_r_ready", 32'(lite_r_ready), 32'd0);
        chk("rst_ar_ready", 32'(nasti_ar_ready), 32'd1);
        rstn = 1'b1;

        for (int i = 0; i < 9; i++) begin
            br = r_q.size();
            run_vec(vt[i]);
            if (i == 0 && br < r_q.size()) chk("single_data", r_q[br].data, 32'hDEADBEEF);
        end

        // Backpressure: stall R for 5 cycles while beat 2 of 4 is presented.
        set_vec(0, 2'd1, 32'h0000_0500, 8'd3, 3'd2, 2'b01, 1'b0, 3'b000, NONE, 4,
                32'h500, 32'h504, 32'h508, 32'h50C, 0, 0, 0, 0);
        bv  = vt[0];
        bla = la_q.size();
        br  = r_q.size();
        start_ar(bv);
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (r_q.size() == br + 1 && nasti_r_valid) break;
        end
        nasti_r_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_data", nasti_r_data, 32'h504 ^ KEY);
            chk("bp_valid", 32'(nasti_r_valid), 32'd1);
            chk("bp_lite_r_ready", 32'(lite_r_ready), 32'd0);
        end
        chk("bp_lite_ar_count", 32'(la_q.size() - bla), 32'd3);
        nasti_r_ready = 1'b1;
        wait_done(br, 4);
        check_burst(bv, bla, br);

        // Reset while waiting on Lite R data, then a clean single-beat burst.
        set_vec(0, 2'd1, 32'h0000_0600, 8'd3, 3'd2, 2'b01, 1'b1, 3'b000, NONE, 4,
                32'h600, 32'h604, 32'h608, 32'h60C, 0, 0, 0, 0);
        bv = vt[0];
        br = r_q.size();
        start_ar(bv);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (lite_r_valid) break;
        end
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_r_valid", 32'(nasti_r_valid), 32'd0);
        chk("mid_rst_lite_ar_valid", 32'(lite_ar_valid), 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ar_ready", 32'(nasti_ar_ready), 32'd1);
        chk("rst_no_beats", 32'(r_q.size() - br), 32'd0);
        set_vec(0, 2'd1, 32'h0000_0100, 8'd0, 3'd2, 2'b01, 1'b1, 3'b000, NONE, 1,
                32'h100, 0, 0, 0, 0, 0, 0, 0);
        run_vec(vt[0]);

        chk("max_outstanding", 32'(max_out), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
